// File: rtl/trap_scheduler.sv
// trap_scheduler: arbitrates pipeline exceptions and pending interrupts into single trap_en pulses.
// Revision 1.0
`default_nettype none

module trap_scheduler #(
  parameter int NUM_EXC_SRC = 3,
  parameter int XLEN        = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_EXC_SRC-1:0]        exc_valid,
  input  logic [NUM_EXC_SRC*6-1:0]      exc_code,
  input  logic [NUM_EXC_SRC*XLEN-1:0]   exc_pc,
  input  logic [NUM_EXC_SRC*XLEN-1:0]   exc_tval,
  input  logic [XLEN-1:0]               mip,
  input  logic [XLEN-1:0]               mie,
  input  logic [XLEN-1:0]               mideleg,
  input  logic                          mstatus_mie,
  input  logic                          sstatus_sie,
  input  logic [1:0]                    curr_priv_mode,
  input  logic                          pipe_empty,
  input  logic [XLEN-1:0]               resume_pc,
  output logic                          hold,
  output logic                          stall_fetch,
  output logic                          flush,
  output logic                          trap_en,
  output logic [XLEN-1:0]               trap_cause,
  output logic [XLEN-1:0]               trap_pc,
  output logic [XLEN-1:0]               trap_mtval,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    TRAP     = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  // Interrupt codes in descending priority: MEI, MSI, MTI, SEI, SSI, STI.
  localparam logic [3:0] IRQ_PRIO [6] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

  state_e            state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   tval_q, tval_d;

  logic              exc_any;
  logic [5:0]        exc_code_sel;
  logic [XLEN-1:0]   exc_pc_sel;
  logic [XLEN-1:0]   exc_tval_sel;
  logic [XLEN-1:0]   exc_cause;

  logic              m_ok;
  logic              s_ok;
  logic              irq_valid;
  logic [3:0]        irq_code;
  logic [XLEN-1:0]   irq_cause;

  logic              unused_irq_bits;
  assign unused_irq_bits = ^{mip, mie, mideleg};

  // Ascending scan so the oldest (highest-index) stage overrides younger ones.
  always_comb begin
    exc_any      = |exc_valid;
    exc_code_sel = '0;
    exc_pc_sel   = '0;
    exc_tval_sel = '0;
    for (int i = 0; i < NUM_EXC_SRC; i++) begin
      if (exc_valid[i]) begin
        exc_code_sel = exc_code[6*i +: 6];
        exc_pc_sel   = exc_pc[XLEN*i +: XLEN];
        exc_tval_sel = exc_tval[XLEN*i +: XLEN];
      end
    end
    exc_cause       = '0;
    exc_cause[5:0]  = exc_code_sel;
  end

  // Delegated interrupts are only visible below M; non-delegated ones always preempt lower modes.
  always_comb begin
    m_ok      = (curr_priv_mode != 2'b11) || mstatus_mie;
    s_ok      = (curr_priv_mode == 2'b00) || ((curr_priv_mode == 2'b01) && sstatus_sie);
    irq_valid = 1'b0;
    irq_code  = '0;
    for (int k = 5; k >= 0; k--) begin
      if (mip[IRQ_PRIO[k]] && mie[IRQ_PRIO[k]] &&
          (mideleg[IRQ_PRIO[k]] ? s_ok : m_ok)) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_PRIO[k];
      end
    end
    irq_cause           = '0;
    irq_cause[XLEN-1]   = 1'b1;
    irq_cause[3:0]      = irq_code;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    tval_d  = tval_q;
    case (state_q)
      IDLE: begin
        if (exc_any) begin
          cause_d = exc_cause;
          pc_d    = exc_pc_sel;
          tval_d  = exc_tval_sel;
          state_d = TRAP;
        end else if (irq_valid) begin
          cause_d = irq_cause;
          tval_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (exc_any) begin
          cause_d = exc_cause;
          pc_d    = exc_pc_sel;
          tval_d  = exc_tval_sel;
          state_d = TRAP;
        end else if (pipe_empty) begin
          if (irq_valid) begin
            cause_d = irq_cause;
            pc_d    = resume_pc;
            tval_d  = '0;
            state_d = TRAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      TRAP:     state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
    end
  end

  assign hold        = ((state_q == IDLE) && exc_any) || (state_q == TRAP) || (state_q == REDIRECT);
  assign stall_fetch = (state_q == DRAIN) || (state_q == TRAP);
  assign flush       = (state_q == TRAP) || (state_q == REDIRECT);
  assign trap_en     = (state_q == TRAP);
  assign busy        = (state_q != IDLE);
  assign trap_cause  = cause_q;
  assign trap_pc     = pc_q;
  assign trap_mtval  = tval_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_scheduler.sv
// tb_trap_scheduler: directed scenarios plus randomized traffic against a rule-level trap model.
// Revision 1.0
`default_nettype none

module tb_trap_scheduler;

  localparam int N    = 3;
  localparam int XLEN = 64;

  // Control vector {busy, hold, stall_fetch, flush, trap_en} per phase.
  localparam logic [4:0] C_IDLE     = 5'b00000;
  localparam logic [4:0] C_IDLE_EXC = 5'b01000;
  localparam logic [4:0] C_DRAIN    = 5'b10100;
  localparam logic [4:0] C_TRAP     = 5'b11111;
  localparam logic [4:0] C_REDIR    = 5'b11010;

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         exc_valid;
  logic [N*6-1:0]       exc_code;
  logic [N*XLEN-1:0]    exc_pc;
  logic [N*XLEN-1:0]    exc_tval;
  logic [XLEN-1:0]      mip, mie, mideleg;
  logic                 mstatus_mie, sstatus_sie;
  logic [1:0]           curr_priv_mode;
  logic                 pipe_empty;
  logic [XLEN-1:0]      resume_pc;
  logic                 hold, stall_fetch, flush, trap_en, busy;
  logic [XLEN-1:0]      trap_cause, trap_pc, trap_mtval;

  int vecs = 0;
  int errs = 0;

  trap_scheduler #(.NUM_EXC_SRC(N), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mip(mip), .mie(mie), .mideleg(mideleg),
    .mstatus_mie(mstatus_mie), .sstatus_sie(sstatus_sie), .curr_priv_mode(curr_priv_mode),
    .pipe_empty(pipe_empty), .resume_pc(resume_pc),
    .hold(hold), .stall_fetch(stall_fetch), .flush(flush), .trap_en(trap_en),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_mtval(trap_mtval), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ctl();
    return {busy, hold, stall_fetch, flush, trap_en};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_valid      = '0;
    exc_code       = '0;
    exc_pc         = '0;
    exc_tval       = '0;
    mip            = '0;
    mie            = '0;
    mideleg        = '0;
    mstatus_mie    = 1'b0;
    sstatus_sie    = 1'b0;
    curr_priv_mode = 2'd3;
    pipe_empty     = 1'b0;
    resume_pc      = '0;
  endtask

  // Rule-level interrupt choice: walk the architectural priority list, return code or -1.
  function automatic int ref_irq();
    int order [6] = '{11, 3, 7, 9, 1, 5};
    bit taken;
    for (int k = 0; k < 6; k++) begin
      if (mip[order[k]] && mie[order[k]]) begin
        if (mideleg[order[k]])
          taken = (curr_priv_mode == 2'd0) || (curr_priv_mode == 2'd1 && sstatus_sie);
        else
          taken = (curr_priv_mode != 2'd3) || mstatus_mie;
        if (taken) return order[k];
      end
    end
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] irq_cause(int code);
    logic [XLEN-1:0] c;
    c = (64'h1 << 63) + 64'(code);
    return c;
  endfunction

  function automatic int ref_exc_src();
    for (int i = N - 1; i >= 0; i--)
      if (exc_valid[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    vecs++;
    if (ctl() !== C_IDLE) begin errs++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), C_IDLE); end
    vecs++;
    if ({trap_cause, trap_pc, trap_mtval} !== '0) begin
      errs++; $display("FAIL reset_latches got=%h/%h/%h exp=0", trap_cause, trap_pc, trap_mtval);
    end
  endtask

  task automatic test_exception();
    clear_inputs();
    exc_valid        = 3'b010;
    exc_code[11:6]   = 6'd2;
    exc_pc[127:64]   = 64'h8000_0010;
    exc_tval[127:64] = 64'hDEAD;
    #1;
    vecs++;
    if (ctl() !== C_IDLE_EXC) begin errs++; $display("FAIL exc_hold got=%b exp=%b", ctl(), C_IDLE_EXC); end
    tick();
    clear_inputs();
    vecs++;
    if (ctl() !== C_TRAP) begin errs++; $display("FAIL exc_trap_ctl got=%b exp=%b", ctl(), C_TRAP); end
    vecs++;
    if (trap_cause !== 64'h2 || trap_pc !== 64'h8000_0010 || trap_mtval !== 64'hDEAD) begin
      errs++; $display("FAIL exc_fields got=%h/%h/%h exp=2/80000010/dead", trap_cause, trap_pc, trap_mtval);
    end
    tick();
    vecs++;
    if (ctl() !== C_REDIR) begin errs++; $display("FAIL exc_redirect got=%b exp=%b", ctl(), C_REDIR); end
    tick();
    vecs++;
    if (ctl() !== C_IDLE) begin errs++; $display("FAIL exc_idle got=%b exp=%b", ctl(), C_IDLE); end
  endtask

  task automatic test_exc_priority();
    clear_inputs();
    exc_valid = 3'b111;
    exc_code  = {6'd13, 6'd5, 6'd2};
    exc_pc    = {64'hC000, 64'hB000, 64'hA000};
    exc_tval  = {64'h33, 64'h22, 64'h11};
    tick();
    clear_inputs();
    vecs++;
    if (trap_en !== 1'b1 || trap_cause !== 64'd13 || trap_pc !== 64'hC000 || trap_mtval !== 64'h33) begin
      errs++; $display("FAIL exc_prio got=%b/%h/%h/%h exp=1/d/c000/33", trap_en, trap_cause, trap_pc, trap_mtval);
    end
    tick(); tick();
  endtask

  task automatic test_irq();
    clear_inputs();
    mstatus_mie = 1'b1;
    mip = 64'h888;
    mie = 64'h888;
    tick();
    for (int c = 0; c < 4; c++) begin
      vecs++;
      if (ctl() !== C_DRAIN) begin errs++; $display("FAIL irq_drain c=%0d got=%b exp=%b", c, ctl(), C_DRAIN); end
      if (c < 3) tick();
    end
    pipe_empty = 1'b1;
    resume_pc  = 64'h1000;
    tick();
    vecs++;
    if (ctl() !== C_TRAP || trap_cause !== 64'h8000_0000_0000_000B ||
        trap_pc !== 64'h1000 || trap_mtval !== 64'h0) begin
      errs++; $display("FAIL irq_trap got=%b/%h/%h/%h exp=%b/800000000000000b/1000/0",
                       ctl(), trap_cause, trap_pc, trap_mtval, C_TRAP);
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_deleg();
    clear_inputs();
    mstatus_mie = 1'b1;
    mip = 64'h200; mie = 64'h200; mideleg = 64'h200;
    pipe_empty = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vecs++;
      if (ctl() !== C_IDLE) begin errs++; $display("FAIL deleg_m_mode c=%0d got=%b exp=%b", c, ctl(), C_IDLE); end
    end
    curr_priv_mode = 2'd0;
    tick();
    tick();
    vecs++;
    if (ctl() !== C_TRAP || trap_cause !== irq_cause(9)) begin
      errs++; $display("FAIL deleg_u_mode got=%b/%h exp=%b/%h", ctl(), trap_cause, C_TRAP, irq_cause(9));
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_drain_abort();
    clear_inputs();
    mstatus_mie = 1'b1;
    mip = 64'h80; mie = 64'h80;
    tick(); tick();
    exc_valid       = 3'b100;
    exc_code[17:12] = 6'd5;
    exc_pc[191:128] = 64'h4444;
    tick();
    clear_inputs();
    vecs++;
    if (ctl() !== C_TRAP || trap_cause !== 64'd5 || trap_pc !== 64'h4444) begin
      errs++; $display("FAIL drain_abort got=%b/%h/%h exp=%b/5/4444", ctl(), trap_cause, trap_pc, C_TRAP);
    end
    tick(); tick();
  endtask

  task automatic test_irq_cancel();
    int seen;
    clear_inputs();
    mstatus_mie = 1'b1;
    mip = 64'h8; mie = 64'h8;
    tick();
    mip  = '0;
    seen = 0;
    tick(); seen += trap_en;
    tick(); seen += trap_en;
    pipe_empty = 1'b1;
    tick(); seen += trap_en;
    vecs++;
    if (ctl() !== C_IDLE || seen != 0) begin
      errs++; $display("FAIL irq_cancel got=%b pulses=%0d exp=%b pulses=0", ctl(), seen, C_IDLE);
    end
  endtask

  task automatic test_reset_in_trap();
    clear_inputs();
    exc_valid    = 3'b001;
    exc_code[5:0] = 6'd7;
    exc_pc[63:0]  = 64'h1234;
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vecs++;
    if (ctl() !== C_IDLE || trap_cause !== '0 || trap_pc !== '0) begin
      errs++; $display("FAIL reset_in_trap got=%b/%h/%h exp=%b/0/0", ctl(), trap_cause, trap_pc, C_IDLE);
    end
  endtask

  task automatic test_random(int iters);
    int src, code, code2, n;
    logic [XLEN-1:0] exp_pc;
    for (int it = 0; it < iters; it++) begin
      clear_inputs();
      if ($urandom_range(0, 2) == 0) exc_valid = N'($urandom_range(1, 7));
      exc_code       = 18'($urandom);
      exc_pc         = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exc_tval       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      mip            = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      mie            = {$urandom, $urandom};
      mideleg        = {$urandom, $urandom};
      mstatus_mie    = 1'($urandom);
      sstatus_sie    = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       curr_priv_mode = 2'd0;
        1:       curr_priv_mode = 2'd1;
        default: curr_priv_mode = 2'd3;
      endcase
      #1;
      src = ref_exc_src();
      if (src >= 0) begin
        vecs++;
        if (ctl() !== C_IDLE_EXC) begin errs++; $display("FAIL rnd_exc_hold it=%0d got=%b exp=%b", it, ctl(), C_IDLE_EXC); end
        tick();
        vecs++;
        if (ctl() !== C_TRAP || trap_cause !== 64'(exc_code[6*src +: 6]) ||
            trap_pc !== exc_pc[XLEN*src +: XLEN] || trap_mtval !== exc_tval[XLEN*src +: XLEN]) begin
          errs++; $display("FAIL rnd_exc it=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", it, ctl(), trap_cause,
                           trap_pc, trap_mtval, C_TRAP, 64'(exc_code[6*src +: 6]),
                           exc_pc[XLEN*src +: XLEN], exc_tval[XLEN*src +: XLEN]);
        end
        tick(); tick();
      end else begin
        code = ref_irq();
        tick();
        if (code < 0) begin
          vecs++;
          if (ctl() !== C_IDLE) begin errs++; $display("FAIL rnd_no_irq it=%0d got=%b exp=%b", it, ctl(), C_IDLE); end
        end else begin
          n = $urandom_range(0, 3);
          for (int c = 0; c <= n; c++) begin
            vecs++;
            if (ctl() !== C_DRAIN) begin errs++; $display("FAIL rnd_drain it=%0d got=%b exp=%b", it, ctl(), C_DRAIN); end
            if (c < n) tick();
          end
          if ($urandom_range(0, 1) == 1)
            mip = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
          pipe_empty = 1'b1;
          resume_pc  = {$urandom, $urandom};
          exp_pc     = resume_pc;
          code2      = ref_irq();
          tick();
          vecs++;
          if (code2 < 0) begin
            if (ctl() !== C_IDLE) begin errs++; $display("FAIL rnd_irq_gone it=%0d got=%b exp=%b", it, ctl(), C_IDLE); end
          end else if (ctl() !== C_TRAP || trap_cause !== irq_cause(code2) ||
                       trap_pc !== exp_pc || trap_mtval !== '0) begin
            errs++; $display("FAIL rnd_irq it=%0d got=%b/%h/%h/%h exp=%b/%h/%h/0", it, ctl(), trap_cause,
                             trap_pc, trap_mtval, C_TRAP, irq_cause(code2), exp_pc);
          end
          clear_inputs();
          if (code2 >= 0) begin tick(); tick(); end
        end
      end
      vecs++;
      if (busy !== 1'b0) begin errs++; $display("FAIL rnd_return_idle it=%0d got=%b exp=0", it, busy); end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_exception();
    test_exc_priority();
    test_irq();
    test_deleg();
    test_drain_abort();
    test_irq_cancel();
    test_reset_in_trap();
    test_random(300);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
